// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: size codes, FSM encoding, request metadata.
// Alignment helpers feed the DMEM_MISALIGN_CHECK_EN build (error path) and the default build (forced alignment).
// No logic of its own, so it adds no latency and applies no backpressure.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [2:0] ST_ERR   = 3'd5;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_WAIT  = ST_WAIT,
        S_WRITE = ST_WRITE,
        S_RESP  = ST_RESP
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        S_ERR   = ST_ERR
`endif
    } state_t;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] lane;
    } meta_t;

    // The reserved size code 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return {lo[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/half lane steering: load extract with sign/zero extension, and store merge into an old word.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are meaningful.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = 8'(old_word >> {lane, 3'b000});
        half_sel    = lane[1] ? old_word[31:16] : old_word[15:0];
        load_data   = old_word;
        merged_word = old_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged_word[{lane, 3'b000} +: 8] = new_data[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged_word[{lane[1], 4'b0000} +: 16] = new_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller turning byte/half/word requests into word RAM accesses (RMW for sub-word stores).
// Latency from acceptance to resp_valid: load 3, word store 2, sub-word store 4, misaligned 1 (DMEM_MISALIGN_CHECK_EN).
// One request in flight: req_ready is high only in IDLE; req_valid while busy is ignored.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    state_t            state_q, state_d;
    meta_t             meta_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       data_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic [1:0]        acc_size;
    logic [1:0]        acc_lane;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign accept         = req_valid && (state_q == S_IDLE);
    assign acc_size       = norm_size(req_size);

`ifdef DMEM_MISALIGN_CHECK_EN
    logic acc_mis;
    assign acc_mis  = is_misaligned(acc_size, req_addr[1:0]);
    assign acc_lane = req_addr[1:0];
`else
    assign acc_lane = align_lane(acc_size, req_addr[1:0]);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_write && acc_size == SZ_WORD) state_d = S_WRITE;
                    else                                  state_d = S_READ;
`ifdef DMEM_MISALIGN_CHECK_EN
                    if (acc_mis) state_d = S_ERR;
`endif
                end
            end
            S_READ: begin
                ram_re  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT:  state_d = meta_q.write ? S_WRITE : S_RESP;
            S_WRITE: begin
                ram_we  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
`ifdef DMEM_MISALIGN_CHECK_EN
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // data_q carries store data from acceptance, then the RAM word (loads) or merged word (RMW).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                meta_q <= '{write: req_write, size: acc_size,
                            is_unsigned: req_unsigned, lane: acc_lane};
                idx_q  <= req_addr[ADDR_W+1:2];
                data_q <= req_wdata;
`ifdef DMEM_MISALIGN_CHECK_EN
                if (acc_mis) rdata_q <= '0;
`endif
            end
            if (state_q == S_WAIT) begin
                data_q <= meta_q.write ? lane_merged : ram_dout;
                if (!meta_q.write) rdata_q <= lane_load;
            end
            if (state_q == S_WRITE) rdata_q <= '0;
        end
    end

    dmem_lane u_lane (
        .size        (meta_q.size),
        .lane        (meta_q.lane),
        .is_unsigned (meta_q.is_unsigned),
        .old_word    (ram_dout),
        .new_data    (data_q[15:0]),
        .load_data   (lane_load),
        .merged_word (lane_merged)
    );

    assign ram_addr   = idx_q;
    assign ram_din    = data_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases, reset abort, back-to-back loads, then random traffic
// against a word-array reference model; a behavioural RAM sits on the ram_* port.
module tb_dmem_ctrl;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          ram_we;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = '0;

    dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem       [0:(1<<AW)-1];
    logic [31:0] model_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    int            checks = 0;
    int            errors = 0;
    int            re_cnt = 0, we_cnt = 0, resp_cnt = 0, both_cnt = 0;
    logic [AW-1:0] last_we_addr = '0, last_re_addr = '0;
    logic [31:0]   last_we_din = '0;

    always @(negedge clk) begin
        if (ram_re) begin re_cnt++; last_re_addr = ram_addr; end
        if (ram_we) begin we_cnt++; last_we_addr = ram_addr; last_we_din = ram_din; end
        if (ram_re && ram_we) both_cnt++;
        if (resp_valid) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lo);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * lo[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lo);
        logic [31:0] mask;
        int          sh;
        sh   = (sz == 2'd0) ? 8 * lo : 16 * lo[1];
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        logic [1:0]  esz, lo;
        logic        mis;
        int          idx, exp_lat, exp_re, exp_we, re0, we0, lat, g;
        logic [31:0] old, nw, exp_rd;
        esz = (sz == 2'd3) ? 2'd2 : sz;
        lo  = addr[1:0];
        mis = (esz == 2'd1 && lo[0]) || (esz == 2'd2 && lo != 2'd0);
`ifndef DMEM_MISALIGN_CHECK_EN
        if (esz == 2'd1) lo[0] = 1'b0;
        else if (esz == 2'd2) lo = 2'd0;
        mis = 1'b0;
`endif
        idx    = int'(addr[AW+1:2]);
        old    = model_mem[idx];
        nw     = old;
        exp_rd = '0;
        exp_re = 0;
        exp_we = 0;
        if (mis) exp_lat = 1;
        else if (!wr) begin exp_lat = 3; exp_re = 1; exp_rd = ext_load(old, esz, uns, lo); end
        else if (esz == 2'd2) begin exp_lat = 2; exp_we = 1; nw = wd; end
        else begin exp_lat = 4; exp_re = 1; exp_we = 1; nw = merge(old, wd, esz, lo); end

        re0 = re_cnt;
        we0 = we_cnt;
        @(negedge clk);
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        #1;
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (resp_valid) begin lat = n; break; end
        end
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'b0, resp_err}, {31'b0, mis});
        chk("resp_rdata", resp_rdata, exp_rd);
        rd = resp_rdata;
        er = resp_err;
        chk("re_count", re_cnt - re0, exp_re);
        chk("we_count", we_cnt - we0, exp_we);
        if (exp_re != 0) chk("re_addr", {23'b0, last_re_addr}, idx);
        if (exp_we != 0) begin
            chk("we_addr", {23'b0, last_we_addr}, idx);
            chk("we_din", last_we_din, nw);
            model_mem[idx] = nw;
        end
        @(negedge clk);
        chk("pulse_len", {31'b0, resp_valid}, 32'd0);
        chk("rdata_hold", resp_rdata, exp_rd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_ram_re"}, {31'b0, ram_re}, 32'd0);
        chk({tag, "_ram_we"}, {31'b0, ram_we}, 32'd0);
        chk({tag, "_ram_addr"}, {23'b0, ram_addr}, 32'd0);
        chk({tag, "_ram_din"}, ram_din, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] b2b_addr [3];
        logic [1:0]  b2b_size [3];
        int          we0, re0, rsp0, lat, g;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]       = $urandom;
            model_mem[i] = mem[i];
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        #1 rst = 1'b1;

        // Directed cases
        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er);
        chk("plan_word_din", last_we_din, 32'hDEAD_BEEF);
        chk("plan_word_addr", {23'b0, last_we_addr}, 32'd4);
        txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_005A, rd, er);
        chk("plan_byte_din", last_we_din, 32'hDEAD_5AEF);
        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01, rd, er);
        txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er);
        chk("plan_half_s", rd, 32'hFFFF_80FF);
        txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er);
        chk("plan_half_u", rd, 32'h0000_80FF);
        txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er);
        chk("plan_byte0_s", rd, 32'h0000_0001);
        txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er);
        chk("plan_byte3_s", rd, 32'hFFFF_FF80);
        txn(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("plan_mis_err", {31'b0, er}, 32'd1);
`else
        chk("plan_mis_err", {31'b0, er}, 32'd0);
        chk("plan_mis_idx", {23'b0, last_re_addr}, 32'd1);
`endif

        // Reset during the WAIT cycle of a sub-word store
        we0 = we_cnt;
        @(negedge clk);
        #1;
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h25; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_read_phase", {31'b0, ram_re}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_write", we_cnt - we0, 32'd0);
        txn(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, rd, er);

        // Back-to-back loads with req_valid held high throughout
        b2b_addr[0] = 32'h40; b2b_size[0] = 2'b10;
        b2b_addr[1] = 32'h46; b2b_size[1] = 2'b01;
        b2b_addr[2] = 32'h4B; b2b_size[2] = 2'b00;
        re0  = re_cnt;
        rsp0 = resp_cnt;
        @(negedge clk);
        #1;
        req_write = 1'b0; req_unsigned = 1'b0;
        req_addr = b2b_addr[0]; req_size = b2b_size[0]; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            g = 0;
            while (!req_ready && g < 20) begin @(negedge clk); g++; end
            @(posedge clk);
            #1;
            if (i < 2) begin req_addr = b2b_addr[i+1]; req_size = b2b_size[i+1]; end
            else req_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if (resp_valid) begin lat = n; break; end
            end
            chk("b2b_latency", lat, 32'd3);
            chk("b2b_rdata", resp_rdata,
                ext_load(model_mem[int'(b2b_addr[i][AW+1:2])], b2b_size[i], 1'b0, b2b_addr[i][1:0]));
        end
        repeat (4) @(negedge clk);
        chk("b2b_resp_count", resp_cnt - rsp0, 32'd3);
        chk("b2b_re_count", re_cnt - re0, 32'd3);

        // Random traffic over 16 words with random upper address bits
        for (int t = 0; t < 120; t++) begin
            txn(1'($urandom), 2'($urandom),
                1'($urandom), ($urandom & 32'hFFFF_F800) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                $urandom, rd, er);
        end

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], model_mem[i]);
        chk("re_we_overlap", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
